sor_pipe: RTL and testbench



---
 rtl/sor_pipe_if.sv | 34 +++
 rtl/sor_pipe.sv | 129 ++++++++++++
 tb/tb_sor_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sor_pipe_if.sv
// Handshake bundle for the pipelined shift/rotate unit.
// carry_out only exists when SOR_CARRY_EN is defined.
interface sor_pipe_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] select;
    logic [2:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sor;
`ifdef SOR_CARRY_EN
    logic             carry_out;
`endif

    modport slave (
        input  in_valid, data, select, mode, out_ready,
        output in_ready, out_valid, sor
`ifdef SOR_CARRY_EN
        , output carry_out
`endif
    );

    modport master (
        output in_valid, data, select, mode, out_ready,
        input  in_ready, out_valid, sor
`ifdef SOR_CARRY_EN
        , input carry_out
`endif
    );
endinterface

// File: rtl/sor_pipe.sv
// Pipelined log shifter: one registered stage per select bit, global stall on !out_ready.
// Define SOR_CARRY_EN to add a registered carry_out (last bit shifted out).
module sor_pipe #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst,
    sor_pipe_if.slave   bus
);
    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    logic advance;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        // select bits still to be consumed from this stage onward
        localparam int SW = AMT_W - k;

        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_nxt;
        logic [WIDTH-1:0] word_q;
        logic [SW-1:0]    s_in;
        logic [2:0]       m_in;
        logic             v_in;
        logic             valid_q;
`ifdef SOR_CARRY_EN
        logic             c_in;
        logic             c_nxt;
        logic             carry_q;
`endif

        if (k == 0) begin : g_src
            assign w_in = bus.data;
            assign s_in = bus.select;
            assign m_in = bus.mode;
            assign v_in = bus.in_valid;
`ifdef SOR_CARRY_EN
            assign c_in = 1'b0;
`endif
        end else begin : g_src
            assign w_in = g_stage[k-1].word_q;
            assign s_in = g_stage[k-1].g_fwd.sel_q;
            assign m_in = g_stage[k-1].g_fwd.mode_q;
            assign v_in = g_stage[k-1].valid_q;
`ifdef SOR_CARRY_EN
            assign c_in = g_stage[k-1].carry_q;
`endif
        end

        // SRA can sign-fill from the current word: earlier stages already preserved the MSB
        always_comb begin
            w_nxt = w_in;
            if (s_in[0]) begin
                case (m_in)
                    MODE_SLL: w_nxt = w_in << SH;
                    MODE_SRL: w_nxt = w_in >> SH;
                    MODE_SRA: w_nxt = $signed(w_in) >>> SH;
                    MODE_ROL: w_nxt = (w_in << SH) | (w_in >> (WIDTH - SH));
                    MODE_ROR: w_nxt = (w_in >> SH) | (w_in << (WIDTH - SH));
                    default:  w_nxt = w_in;
                endcase
            end
        end

`ifdef SOR_CARRY_EN
        // The last applied stage defines the carry; pass-through stages keep it
        always_comb begin
            c_nxt = c_in;
            if (s_in[0]) begin
                case (m_in)
                    MODE_SLL: c_nxt = w_in[WIDTH-SH];
                    MODE_SRL: c_nxt = w_in[SH-1];
                    MODE_SRA: c_nxt = w_in[SH-1];
                    MODE_ROL: c_nxt = w_in[WIDTH-SH];
                    MODE_ROR: c_nxt = w_in[SH-1];
                    default:  c_nxt = 1'b0;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                carry_q <= 1'b0;
            end else if (advance) begin
                carry_q <= c_nxt;
            end
        end
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                word_q  <= '0;
            end else if (advance) begin
                valid_q <= v_in;
                word_q  <= w_nxt;
            end
        end

        if (k < AMT_W - 1) begin : g_fwd
            logic [SW-2:0] sel_q;
            logic [2:0]    mode_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sel_q  <= '0;
                    mode_q <= '0;
                end else if (advance) begin
                    sel_q  <= s_in[SW-1:1];
                    mode_q <= m_in;
                end
            end
        end
    end

    assign advance       = !g_stage[AMT_W-1].valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = g_stage[AMT_W-1].valid_q;
    assign bus.sor       = g_stage[AMT_W-1].word_q;
`ifdef SOR_CARRY_EN
    assign bus.carry_out = g_stage[AMT_W-1].carry_q;
`endif

endmodule

// File: tb/tb_sor_pipe.sv
// Directed self-checking bench for sor_pipe (WIDTH=8): single ops, streaming, stall and reset.
module tb_sor_pipe;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sor_pipe_if #(.WIDTH(WIDTH)) bus ();
    sor_pipe #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] stream_d [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [7:0] stream_e [8] = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F};

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_carry(input string tag, input logic exp);
`ifdef SOR_CARRY_EN
        chk(tag, WIDTH'(bus.carry_out), WIDTH'(exp));
`else
        if (exp === 1'bx) $display("note: %s has unknown carry", tag);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s, input logic [2:0] m);
        bus.in_valid = v;
        bus.data     = d;
        bus.select   = s;
        bus.mode     = m;
    endtask

    task automatic single(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic [2:0] m, input logic [7:0] exp_sor, input logic exp_c);
        drive(1'b1, d, s, m);
        step();
        drive(1'b0, 8'h00, 3'd0, 3'd0);
        step();
        chk($sformatf("%s_early", tag), WIDTH'(bus.out_valid), 8'h00);
        step();
        chk($sformatf("%s_valid", tag), WIDTH'(bus.out_valid), 8'h01);
        chk($sformatf("%s_sor", tag), bus.sor, exp_sor);
        chk_carry($sformatf("%s_carry", tag), exp_c);
        step();
        chk($sformatf("%s_drained", tag), WIDTH'(bus.out_valid), 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, 8'h00, 3'd0, 3'd0);
        step();
        step();
        chk("rst_valid", WIDTH'(bus.out_valid), 8'h00);
        chk("rst_sor", bus.sor, 8'h00);
        chk_carry("rst_carry", 1'b0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", WIDTH'(bus.in_ready), 8'h01);

        single("sll6",  8'hA6, 3'd6, 3'b000, 8'h80, 1'b1);
        single("rol6",  8'hA6, 3'd6, 3'b011, 8'hA9, 1'b1);
        single("srl3",  8'hA6, 3'd3, 3'b001, 8'h14, 1'b1);
        single("sra3",  8'hA6, 3'd3, 3'b010, 8'hF4, 1'b1);
        single("ror1",  8'hA6, 3'd1, 3'b100, 8'h53, 1'b0);
        single("sll7",  8'h01, 3'd7, 3'b000, 8'h80, 1'b0);
        single("srl7",  8'h80, 3'd7, 3'b001, 8'h01, 1'b0);
        single("sra7",  8'h80, 3'd7, 3'b010, 8'hFF, 1'b0);
        single("sra2p", 8'h7C, 3'd2, 3'b010, 8'h1F, 1'b0);
        single("rol1",  8'h81, 3'd1, 3'b011, 8'h03, 1'b1);
        single("ror3",  8'h0D, 3'd3, 3'b100, 8'hA1, 1'b1);
        single("sll1",  8'hC3, 3'd1, 3'b000, 8'h86, 1'b1);
        single("ill101", 8'h5C, 3'd3, 3'b101, 8'h5C, 1'b0);
        single("ill110", 8'h3E, 3'd7, 3'b110, 8'h3E, 1'b0);
        single("ill111", 8'hA6, 3'd5, 3'b111, 8'hA6, 1'b0);
        for (int m = 0; m < 8; m++) begin
            single($sformatf("sel0_m%0d", m), 8'hA6, 3'd0, 3'(m), 8'hA6, 1'b0);
        end

        // back-to-back stream, nibble swap via ROL 4
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, stream_d[i], 3'd4, 3'b011);
            step();
            chk($sformatf("stream_in_ready%0d", i), WIDTH'(bus.in_ready), 8'h01);
            if (i >= 2) begin
                chk($sformatf("stream_valid%0d", i - 2), WIDTH'(bus.out_valid), 8'h01);
                chk($sformatf("stream_sor%0d", i - 2), bus.sor, stream_e[i - 2]);
                chk_carry($sformatf("stream_carry%0d", i - 2), 1'b1);
            end else begin
                chk($sformatf("stream_fill%0d", i), WIDTH'(bus.out_valid), 8'h00);
            end
        end
        drive(1'b0, 8'h00, 3'd0, 3'd0);
        for (int j = 6; j < 8; j++) begin
            step();
            chk($sformatf("stream_valid%0d", j), WIDTH'(bus.out_valid), 8'h01);
            chk($sformatf("stream_sor%0d", j), bus.sor, stream_e[j]);
        end
        step();
        chk("stream_end", WIDTH'(bus.out_valid), 8'h00);

        // stall with full pipe: SLL by 1 of 01,02,03 then 04 waiting at the input
        drive(1'b1, 8'h01, 3'd1, 3'b000);
        step();
        drive(1'b1, 8'h02, 3'd1, 3'b000);
        step();
        drive(1'b1, 8'h03, 3'd1, 3'b000);
        bus.out_ready = 1'b0;
        step();
        drive(1'b1, 8'h04, 3'd1, 3'b000);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_in_ready%0d", i), WIDTH'(bus.in_ready), 8'h00);
            chk($sformatf("stall_valid%0d", i), WIDTH'(bus.out_valid), 8'h01);
            chk($sformatf("stall_sor%0d", i), bus.sor, 8'h02);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", WIDTH'(bus.in_ready), 8'h01);
        step();
        drive(1'b0, 8'h00, 3'd0, 3'd0);
        chk("release_sor1", bus.sor, 8'h04);
        step();
        chk("release_sor2", bus.sor, 8'h06);
        step();
        chk("release_valid3", WIDTH'(bus.out_valid), 8'h01);
        chk("release_sor3", bus.sor, 8'h08);
        step();
        chk("release_end", WIDTH'(bus.out_valid), 8'h00);

        // reset with three words in flight, output stalled
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h11, 3'd2, 3'b000);
        step();
        drive(1'b1, 8'h22, 3'd2, 3'b000);
        step();
        drive(1'b1, 8'h33, 3'd2, 3'b000);
        step();
        drive(1'b0, 8'h00, 3'd0, 3'd0);
        chk("flight_valid", WIDTH'(bus.out_valid), 8'h01);
        chk("flight_sor", bus.sor, 8'h44);
        rst = 1'b1;
        step();
        chk("midrst_valid", WIDTH'(bus.out_valid), 8'h00);
        chk("midrst_sor", bus.sor, 8'h00);
        chk_carry("midrst_carry", 1'b0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("midrst_in_ready", WIDTH'(bus.in_ready), 8'h01);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst_quiet%0d", i), WIDTH'(bus.out_valid), 8'h00);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
